// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core MEM stage and a data memory.
// master drives requests and accepts responses; slave is the memory side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a valid/ready port with wait states.
// Ports: clk, reset_n (async, active low), bus (slave: req_*/rsp_*).
// Optional DMEM_ALIGN_CHECK_EN: flags misaligned/illegal byte enables.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          wr;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   rdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          accept;
  logic          access;
  logic          ok;

  assign off    = bus.req_addr - ADDR_BASE;
  assign accept = bus.req_valid && (state == S_IDLE);
  assign access = (state == S_WAIT) && (cnt == 4'd0);

  logic [31-AW:0] unused_off;
  assign unused_off = {off[31:AW+2], off[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lo;
  logic       err;

  // be encodes size; its lowest lane must match the byte offset.
  always_comb begin
    ok = 1'b0;
    case (be)
      4'b0000: ok = wr;
      4'b0001: ok = (lo == 2'd0);
      4'b0010: ok = (lo == 2'd1);
      4'b0100: ok = (lo == 2'd2);
      4'b1000: ok = (lo == 2'd3);
      4'b0011: ok = (lo == 2'd0);
      4'b1100: ok = (lo == 2'd2);
      4'b1111: ok = (lo == 2'd0);
      default: ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo  <= 2'd0;
      err <= 1'b0;
    end else begin
      if (accept) lo <= bus.req_addr[1:0];
      if (access) err <= !ok;
    end
  end

  assign bus.rsp_err = err;
`else
  assign ok          = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      wr    <= 1'b0;
      idx   <= '0;
      wdata <= 32'd0;
      be    <= 4'd0;
      rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr    <= bus.req_write;
            idx   <= off[AW+1:2];
            wdata <= bus.req_wdata;
            be    <= bus.req_be;
            cnt   <= 4'(WAIT_CYCLES);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata <= (wr || !ok) ? 32'd0 : mem[idx];
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM array carries no reset; a reset before access leaves it untouched.
  always_ff @(posedge clk) begin
    if (access && wr && ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Byte-array memory model, latency and handshake checks.
module tb_dmem_responder;
  localparam int          DEPTH = 1024;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC),
    .ADDR_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  byte unsigned mb [DEPTH*4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return int'(d % 32'(DEPTH));
  endfunction

  function automatic logic legal(input logic wr, input logic [31:0] a,
                                 input logic [3:0] be);
`ifdef DMEM_ALIGN_CHECK_EN
    int n;
    int lo;
    n = $countones(be);
    lo = 0;
    if (be == 4'd0) return wr;
    while (!be[lo]) lo++;
    return (n == 1 || n == 2 || n == 4) && lo == int'(a[1:0])
           && (lo % n) == 0 && be == 4'(((1 << n) - 1) << lo);
`else
    return 1'b1 | wr | a[0] | be[0];
`endif
  endfunction

  task automatic model(input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] er, output logic ee);
    int w;
    logic ok;
    w = widx(a);
    ok = legal(wr, a, be);
    ee = !ok;
    er = 32'd0;
    if (ok) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mb[w*4+i] = wd[8*i +: 8];
      end else begin
        er = {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
      end
    end
  endtask

  task automatic accept_req(input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    accept_req(wr, a, wd, be);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(WAITC + 1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    if (hold > 0) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = BASE;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, rd);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_clear", 32'(bus.rsp_valid), 32'd0);
    check("ready_after", 32'(bus.req_ready), 32'd1);
    check("rdata_keep", bus.rsp_rdata, rd);
    bus.req_valid = 1'b0;
  endtask

  task automatic run(input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int hold, output logic [31:0] rd);
    logic [31:0] er;
    logic ee;
    logic e;
    model(wr, a, wd, be, er, ee);
    xact(wr, a, wd, be, hold, rd, e);
    check("rdata", rd, er);
    check("err", 32'(e), 32'(ee));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] er;
    logic ee;
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_be    = 4'd0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int w = 0; w < 64; w++)
      run(1'b1, BASE + 32'(w * 4), $urandom, 4'hF, 0, rd);

    // T1 / T2
    run(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    check("t1_store_rdata", rd, 32'd0);
    run(1'b0, BASE + 32'h10, 32'd0, 4'h0, 0, rd);
    check("t1_load", rd, 32'hDEADBEEF);
    run(1'b1, BASE + 32'h11, 32'h0000AB00, 4'b0010, 0, rd);
    run(1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, rd);
    check("t2_load", rd, 32'hDEADABEF);

    // T3: stalled response with a queued request
    run(1'b0, BASE + 32'h10, 32'd0, 4'hF, 5, rd);
    check("t3_load", rd, 32'hDEADABEF);

    // T4: wrap
    run(1'b1, BASE + 32'h1010, 32'h12345678, 4'hF, 0, rd);
    run(1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, rd);
    check("t4_wrap", rd, 32'h12345678);

    // T5: reset during WAIT drops the store
    run(1'b1, BASE + 32'h20, 32'd0, 4'hF, 0, rd);
    accept_req(1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'hF);
    reset_n = 1'b0;
    #1;
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, BASE + 32'h20, 32'd0, 4'hF, 0, rd);
    check("t5_load", rd, 32'd0);

    // Reset during RESP keeps the completed store
    accept_req(1'b1, BASE + 32'h24, 32'h5A5A5A5A, 4'hF);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_rst_lat", 32'(n), 32'(WAITC + 1));
    reset_n = 1'b0;
    #1;
    check("resp_rst_valid", 32'(bus.rsp_valid), 32'd0);
    model(1'b1, BASE + 32'h24, 32'h5A5A5A5A, 4'hF, er, ee);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, BASE + 32'h24, 32'd0, 4'hF, 0, rd);
    check("resp_rst_load", rd, 32'h5A5A5A5A);

`ifdef DMEM_ALIGN_CHECK_EN
    // T6
    xact(1'b1, BASE + 32'h12, 32'hFFFFFFFF, 4'hF, 0, rd, ee);
    check("t6_err", 32'(ee), 32'd1);
    run(1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, rd);
    check("t6_unchanged", rd, 32'h12345678);
    xact(1'b1, BASE + 32'h12, 32'hBEEF0000, 4'b1100, 0, rd, ee);
    check("t6_ok", 32'(ee), 32'd0);
    model(1'b1, BASE + 32'h12, 32'hBEEF0000, 4'b1100, er, ee);
    run(1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, rd);
    check("t6_half", rd, 32'hBEEF5678);
`endif

    for (int t = 0; t < 200; t++) begin
      logic        wr;
      logic [31:0] a;
      int          w;
      int          k;
      wr = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 63);
      k = $urandom_range(0, 3);
      a = BASE + 32'((w + k * DEPTH) * 4 + $urandom_range(0, 3));
      run(wr, a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
